uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter that sits directly downstream of the CPU's memory port (`Mem_Addr`, `Mem_Write`, `Data_Out`). It decodes two addresses at the top of the address space, buffers written bytes in a small FIFO, and serialises them 8N1 on `Tx`. Status is returned combinationally on `Rd_Data` for the top-level read mux, which is steered by `Sel`.

## Interface
Parameters:
- `BASE_ADDR`, 16'hFF00: address of the TX data register. The status register is at `BASE_ADDR+1`.
- `CLK_DIV`, 5208: clocks per bit (50 MHz / 9600 baud). Legal range is ≥2.
- `FIFO_DEPTH`, 4: byte entries. Must be a power of two, from 2 to 16.

Ports:
- `Clock`, input, 1: system clock. All state changes on the rising edge.
- `Reset`, input, 1: asynchronous, active-high.
- `Mem_Addr`, input, 16: CPU address.
- `Mem_Write`, input, 1: CPU write strobe, sampled on the rising edge of `Clock`.
- `Data_Out`, input, 16: CPU write data. Only bits [7:0] are used.
- `Sel`, output, 1: combinational. High when `Mem_Addr` equals `BASE_ADDR` or `BASE_ADDR+1`.
- `Rd_Data`, output, 16: combinational. Status word when `Mem_Addr==BASE_ADDR+1`, otherwise 16'h0000.
- `Tx`, output, 1: serial line, registered, idle high.

## Operation
- **Data register write.** `Mem_Write` with `Mem_Addr==BASE_ADDR` pushes `Data_Out[7:0]` into the FIFO.
- **Status register write.** `Mem_Write` with `Mem_Addr==BASE_ADDR+1` clears the overflow flag. The written data is ignored.
- **Status word layout:**
  - bit 0: full
  - bit 1: empty
  - bit 2: busy (FSM not IDLE)
  - bit 3: overflow (sticky)
  - bits [8:4]: FIFO count
  - bits [15:9]: 0
- **Push when full.** A push while full with no simultaneous pop is dropped and sets overflow.
- **Simultaneous push and pop when full.** The push is accepted; count is unchanged.
- **Pop rules.** A pop occurs only when the FIFO is non-empty. FIFO pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: `Tx=1`. If non-empty, pop into the shift register and go to START.
  - START: `Tx=0` for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `Tx=shift[0]` for `CLK_DIV` cycles per bit, shifting right. Bits go out LSB first. After bit 7, go to STOP.
  - STOP: `Tx=1` for `CLK_DIV` cycles. On the final STOP cycle, if non-empty, pop and go directly to START; otherwise go to IDLE.
- **Baud counter.** Counts 0..`CLK_DIV-1`. Its width is the clog2 of `CLK_DIV`. It reloads to 0 on every state change.
- **Reset values:**
  - state IDLE, `Tx=1`
  - FIFO empty (count 0), pointers 0
  - overflow 0
  - shift register 0, baud counter 0, bit index 0
  - resulting status word: 16'h0002

## Timing
- **Push.** A write accepted at edge k is visible in count and status after edge k.
- **Start latency.** With the FSM in IDLE, a push at edge k is popped at edge k+1, and `Tx` falls after edge k+1.
- **Frame length.** One frame is exactly 10×`CLK_DIV` cycles (11× with parity).
- **Back-to-back frames.** No idle cycle between frames when the FIFO is non-empty.
- **Reset mid-frame.** `Tx` goes high immediately (asynchronously). The frame in flight and all FIFO contents are discarded.
- **Status reads.** Reflect register state as of the last edge. A same-cycle write is not yet visible.

## Configuration
- **`UART_PARITY_EN` defined.**
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (the XOR of the 8 data bits) for `CLK_DIV` cycles.
  - Status bit 9 reads 1, meaning parity is present.
- **`UART_PARITY_EN` undefined.**
  - No PARITY state; frames are 8N1.
  - Status bit 9 reads 0.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding as a typedef.
  - Register offsets: `UART_DATA_OFS=0`, `UART_STAT_OFS=1`.
  - Status bit positions.
- **Sub-module `tx_fifo`:** a parameterised synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, count.
  - `dout` shows the head entry combinationally.
- **Top of `uart_tx_port`:** address decode, overflow flag, status mux, baud counter, FSM and shift register.

## Test plan
Bench uses `CLK_DIV=4` and `FIFO_DEPTH=4`.
- **Reset.** Assert `Reset` mid-clock -> `Tx=1` immediately; status at `BASE_ADDR+1` reads 16'h0002; `Sel=1`, and `Sel=0` at address 16'h0000.
- **Single byte.** Write 16'h0055 to 16'hFF00 -> starting one edge later, `Tx` is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; then IDLE, busy=0.
- **Back-to-back.** Write 0xA5 then 0x3C on consecutive cycles -> two frames totalling 80 cycles with no gap; the stop bit of the first frame is followed directly by the start bit of the second.
- **Overflow.** While the first frame is in flight, issue 6 writes -> 4 entries accepted (count 4, full=1), overflow=1. A write to 16'hFF01 clears overflow; count is unchanged.
- **Full push-and-pop.** With the FIFO full, time a push on the FSM's pop edge -> count stays 4, no overflow, the new byte is transmitted last.
- **Reset mid-frame.** Pulse `Reset` during DATA bit 3 with 2 entries queued -> `Tx=1` immediately, status 16'h0002, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Optional build macro: UART_PARITY_EN (adds an even-parity bit to every frame).
package uart_pkg;

  // Transmit FSM state encoding.
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Register offsets from the base address.
  localparam logic [15:0] UART_DATA_OFS = 16'd0;
  localparam logic [15:0] UART_STAT_OFS = 16'd1;

  // Status word bit positions.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_MSB   = 8;
  localparam int STAT_PAR_BIT   = 9;

  // Assemble the status word; unused upper bits read as zero.
  function automatic logic [15:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [4:0] cnt,
                                              input logic       par);
    logic [15:0] s;
    s = '0;
    s[STAT_FULL_BIT]               = full;
    s[STAT_EMPTY_BIT]              = empty;
    s[STAT_BUSY_BIT]               = busy;
    s[STAT_OVF_BIT]                = ovf;
    s[STAT_CNT_MSB:STAT_CNT_LSB]   = cnt;
    s[STAT_PAR_BIT]                = par;
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Parameterised synchronous FIFO holding bytes waiting for the transmitter.
// Head entry is shown combinationally on dout_o. Pops on an empty FIFO are
// ignored; a push while full is accepted only together with a pop.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy update; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: data register at BASE_ADDR, status at
// BASE_ADDR+1. Written bytes queue in tx_fifo and are serialised LSB first.
// Optional build macro: UART_PARITY_EN inserts an even-parity bit before STOP
// and sets status bit 9.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 5208,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Mem_Addr,
  input  logic        Mem_Write,
  input  logic [15:0] Data_Out,
  output logic        Sel,
  output logic [15:0] Rd_Data,
  output logic        Tx
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [15:0]   DATA_ADDR = BASE_ADDR + UART_DATA_OFS;
  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + UART_STAT_OFS;

`ifdef UART_PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  // Address decode and write strobes.
  logic data_hit, stat_hit, wr_data, wr_stat;
  assign data_hit = (Mem_Addr == DATA_ADDR);
  assign stat_hit = (Mem_Addr == STAT_ADDR);
  assign wr_data  = Mem_Write & data_hit;
  assign wr_stat  = Mem_Write & stat_hit;
  assign Sel      = data_hit | stat_hit;

  // Only the low byte of the write bus is meaningful.
  logic unused_data_hi;
  assign unused_data_hi = ^Data_Out[15:8];

  // FIFO interface.
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .din_i   (Data_Out[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Transmitter state.
  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          baud_done;
  logic          parity_bit;

  assign baud_done = (baud_q == BAUD_LAST);

`ifdef UART_PARITY_EN
  logic parity_q, parity_d;

  // Even parity of the byte in flight, captured when it is popped.
  always_comb begin
    parity_d = parity_q;
    if (fifo_pop) parity_d = ^fifo_dout;
  end

  // Parity register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign parity_bit = parity_q;
`else
  assign parity_bit = 1'b1;
`endif

  // Frame sequencer: baud counter restarts on every state change, and the
  // last STOP cycle pops the next byte so frames run back to back.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
          baud_d   = '0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle, registered so Tx is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: set by a dropped push, cleared by any status write.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat)                                  ovf_d = 1'b0;
    else if (wr_data && fifo_full && !fifo_pop)   ovf_d = 1'b1;
  end

  // Transmitter and flag registers; reset forces the line idle immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Tx = tx_q;

  // Status read path, combinational from registered state.
  logic [15:0] status;
  assign status  = pack_status(fifo_full, fifo_empty, (state_q != ST_IDLE),
                               ovf_q, 5'(fifo_count), PAR_PRESENT);
  assign Rd_Data = stat_hit ? status : 16'h0000;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port (CLK_DIV=4, FIFO_DEPTH=4).
// Honours UART_PARITY_EN when defined at compile time.
module tb_uart_tx_port;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam int          FRAME  = NBITS * DIV;
  localparam int          MID3   = FRAME - (4 * DIV + DIV / 2);
  localparam logic [15:0] DATA_A = 16'hFF00;
  localparam logic [15:0] STAT_A = 16'hFF01;
  localparam logic [15:0] PARW   = PAR ? 16'h0200 : 16'h0000;

  // ---------------- clock / reset / DUT ----------------
  logic        Clock     = 1'b0;
  logic        Reset     = 1'b1;
  logic [15:0] Mem_Addr  = 16'h0000;
  logic        Mem_Write = 1'b0;
  logic [15:0] Data_Out  = 16'h0000;
  logic        Sel;
  logic [15:0] Rd_Data;
  logic        Tx;

  always #5 Clock = ~Clock;

  uart_tx_port #(
    .BASE_ADDR  (16'hFF00),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Mem_Addr  (Mem_Addr),
    .Mem_Write (Mem_Write),
    .Data_Out  (Data_Out),
    .Sel       (Sel),
    .Rd_Data   (Rd_Data),
    .Tx        (Tx)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of waiting bytes plus a countdown of cycles left in the frame on
  // the wire. A byte leaves the queue when the line is free or on the last
  // cycle of the current frame. Expected frames carry their start cycle.
  logic [7:0]   mq[$];
  int           m_left = 0;
  logic         m_ovf  = 1'b0;
  int unsigned  cyc    = 0;
  logic [39:0]  exp_q[$];

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s      = 16'h0000;
    s[0]   = (mq.size() == DEPTH);
    s[1]   = (mq.size() == 0);
    s[2]   = (m_left > 0);
    s[3]   = m_ovf;
    s[8:4] = 5'(mq.size());
    s[9]   = PAR;
    return s;
  endfunction

  always @(posedge Clock) begin
    logic       pop_now;
    logic       acc;
    logic [7:0] b;
    cyc++;
    if (Reset) begin
      mq.delete();
      exp_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      pop_now = (m_left <= 1) && (mq.size() > 0);
      acc     = 1'b0;
      if (Mem_Write && Mem_Addr == STAT_A) m_ovf = 1'b0;
      if (Mem_Write && Mem_Addr == DATA_A) begin
        if (mq.size() < DEPTH || pop_now) acc = 1'b1;
        else                              m_ovf = 1'b1;
      end
      if (pop_now) begin
        b = mq.pop_front();
        exp_q.push_back({cyc[31:0], b});
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (acc) mq.push_back(Data_Out[7:0]);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic             mon_active = 1'b0;
  int               mon_cnt    = 0;
  logic             mon_stable = 1'b1;
  logic             mon_have   = 1'b0;
  logic [NBITS-1:0] mon_bits   = '0;
  logic [39:0]      mon_exp    = '0;

  always @(negedge Clock) begin
    if (Reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && Tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_stable = 1'b1;
        mon_bits   = '0;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          mon_have = 1'b0;
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_have = 1'b1;
          chk("frame_start_cycle", cyc, {mon_exp[39:8]});
        end
      end
      if (mon_active) begin
        if (mon_cnt % DIV == 0) mon_bits[mon_cnt / DIV] = Tx;
        else if (Tx !== mon_bits[mon_cnt / DIV]) mon_stable = 1'b0;
        mon_cnt++;
        if (mon_cnt == FRAME) begin
          mon_active = 1'b0;
          chk("bit_width_stable", {31'd0, mon_stable}, 32'd1);
          chk("stop_bit", {31'd0, mon_bits[NBITS-1]}, 32'd1);
          if (mon_have) begin
            chk("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, mon_exp[7:0]});
`ifdef UART_PARITY_EN
            chk("parity_bit", {31'd0, mon_bits[9]}, {31'd0, ^mon_exp[7:0]});
`endif
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    Mem_Write = 1'b0;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    Mem_Addr  = addr;
    Data_Out  = data;
    Mem_Write = 1'b1;
    @(posedge Clock);
    #1;
    Mem_Write = 1'b0;
  endtask

  task automatic check_stat(input string name, input logic [15:0] exp);
    Mem_Write = 1'b0;
    Mem_Addr  = STAT_A;
    #1;
    chk(name, {16'd0, Rd_Data}, {16'd0, exp});
    @(posedge Clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() > 0 || m_left > 0) && n < 10 * FRAME) begin
      idle(1);
      n++;
    end
    idle(2);
    chk(name, {31'd0, (mq.size() == 0 && m_left == 0 && exp_q.size() == 0)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int r;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("tx_in_reset", {31'd0, Tx}, 32'd1);
    Reset = 1'b0;
    idle(2);
    check_stat("reset_status", 16'h0002 | PARW);
    Mem_Addr = STAT_A; #1;
    chk("sel_stat_addr", {31'd0, Sel}, 32'd1);
    Mem_Addr = DATA_A; #1;
    chk("sel_data_addr", {31'd0, Sel}, 32'd1);
    chk("rd_data_addr_zero", {16'd0, Rd_Data}, 32'd0);
    Mem_Addr = 16'h0000; #1;
    chk("sel_zero_addr", {31'd0, Sel}, 32'd0);
    chk("rd_zero_addr", {16'd0, Rd_Data}, 32'd0);
    idle(1);

    // Single byte 0x55
    wr(DATA_A, 16'h0055);
    chk("tx_before_start", {31'd0, Tx}, 32'd1);
    check_stat("push_visible", 16'h0010 | PARW);
    chk("tx_start_fall", {31'd0, Tx}, 32'd0);
    check_stat("busy_in_frame", 16'h0006 | PARW);
    idle(FRAME);
    check_stat("idle_after_frame", 16'h0002 | PARW);

    // Back-to-back frames
    wr(DATA_A, 16'h00A5);
    wr(DATA_A, 16'h003C);
    drain("b2b_drain");

    // Overflow: one byte on the wire, six more written
    wr(DATA_A, 16'h0011);
    idle(2);
    for (int i = 0; i < 6; i++) wr(DATA_A, 16'($urandom_range(0, 255)));
    check_stat("overflow_status", 16'h004D | PARW);
    wr(STAT_A, 16'hFFFF);
    check_stat("overflow_cleared", 16'h0045 | PARW);

    // Push exactly on the pop edge while full
    n = 0;
    while (m_left != 1 && n < 4 * FRAME) begin
      idle(1);
      n++;
    end
    chk("pop_edge_found", {31'd0, (n < 4 * FRAME)}, 32'd1);
    wr(DATA_A, 16'h00E7);
    check_stat("full_push_pop", 16'h0045 | PARW);
    drain("full_drain");

    // Randomised traffic against the model
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 6)       wr(DATA_A, 16'($urandom_range(0, 16'hFFFF)));
      else if (r == 6) wr(STAT_A, 16'($urandom_range(0, 16'hFFFF)));
      else if (r == 7) check_stat("rand_status", model_status());
      else             idle($urandom_range(1, 2 * DIV * NBITS));
    end
    check_stat("rand_status_end", model_status());
    drain("rand_drain");

    // Reset during DATA bit 3 with two bytes queued
    wr(DATA_A, 16'h0055);
    wr(DATA_A, 16'h0021);
    wr(DATA_A, 16'h0022);
    n = 0;
    while (m_left != MID3 && n < 4 * FRAME) begin
      idle(1);
      n++;
    end
    chk("bit3_reached", {31'd0, (n < 4 * FRAME)}, 32'd1);
    #2;
    chk("tx_bit3_low", {31'd0, Tx}, 32'd0);
    Reset = 1'b1;
    #1;
    chk("reset_tx_async", {31'd0, Tx}, 32'd1);
    Mem_Addr = STAT_A;
    #1;
    chk("reset_mid_status", {16'd0, Rd_Data}, {16'd0, 16'h0002 | PARW});
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    idle(3 * FRAME);
    check_stat("post_reset_quiet", 16'h0002 | PARW);
    chk("final_tx_idle", {31'd0, Tx}, 32'd1);
    chk("no_pending_frames", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
